// File: rtl/sun_tracker_if.sv
// sun_tracker_if: lux inputs, stepper step/direction outputs and status of the solar tracker.
interface sun_tracker_if;
    logic        enable;
    logic [15:0] n_lux, e_lux, s_lux, w_lux;
    logic        az_step, az_dir, el_step, el_dir;
    logic [11:0] az_pos, el_pos;
    logic        busy, night;
    modport master (
        output enable, n_lux, e_lux, s_lux, w_lux,
        input  az_step, az_dir, el_step, el_dir, az_pos, el_pos, busy, night
    );
    modport slave (
        input  enable, n_lux, e_lux, s_lux, w_lux,
        output az_step, az_dir, el_step, el_dir, az_pos, el_pos, busy, night
    );
endinterface

// File: rtl/sun_tracker.sv
// sun_tracker: two-axis tracker issuing at most one step per axis toward the brighter side per tick.
// Define SUN_TRACKER_NIGHT_HOME_EN to park at home after NIGHT_EVALS consecutive dark evaluations.
module sun_tracker #(
    parameter int EVAL_PERIOD = 1000000,
    parameter int DEADBAND    = 50,
    parameter int STEP_HIGH   = 100,
    parameter int STEP_LOW    = 100,
    parameter int AZ_MAX      = 2000,
    parameter int EL_MAX      = 500,
    parameter int NIGHT_LUX   = 40,
    parameter int NIGHT_EVALS = 8
) (
    input logic          clk,
    input logic          rst,
    sun_tracker_if.slave bus
);
    localparam int TW = $clog2(EVAL_PERIOD);
    localparam int PW = $clog2((STEP_HIGH > STEP_LOW ? STEP_HIGH : STEP_LOW) + 1);
    localparam logic signed [16:0] DB_P = 17'(DEADBAND);
    localparam logic signed [16:0] DB_N = -DB_P;
    localparam logic [11:0] AZ_TOP = 12'(AZ_MAX);
    localparam logic [11:0] EL_TOP = 12'(EL_MAX);

`ifdef SUN_TRACKER_NIGHT_HOME_EN
    typedef enum logic [2:0] {IDLE, EVAL, AZ_HI, AZ_LO, EL_HI, EL_LO, HOME} state_t;
`else
    typedef enum logic [2:0] {IDLE, EVAL, AZ_HI, AZ_LO, EL_HI, EL_LO} state_t;
`endif

    state_t             r_state;
    logic [TW-1:0]      r_tick;
    logic [PW-1:0]      r_ph;
    logic [15:0]        r_n, r_e, r_s, r_w;
    logic               r_az_step, r_az_dir, r_el_step, r_el_dir, r_el_req;
    logic [11:0]        r_az_pos, r_el_pos;
    logic               w_tick, w_hi_end, w_lo_end;
    logic               w_az_up, w_az_req, w_el_up, w_el_req;
    logic signed [16:0] w_diff_ew, w_diff_ns;
    state_t             w_eval_nx, w_az_lo_nx, w_el_lo_nx;

    assign w_tick    = bus.enable && r_tick == TW'(EVAL_PERIOD - 1);
    assign w_hi_end  = r_ph == PW'(STEP_HIGH - 1);
    assign w_lo_end  = r_ph == PW'(STEP_LOW - 1);
    assign w_diff_ew = {1'b0, r_e} - {1'b0, r_w};
    assign w_diff_ns = {1'b0, r_n} - {1'b0, r_s};
    assign w_az_up   = w_diff_ew > DB_P && r_az_pos < AZ_TOP;
    assign w_az_req  = w_az_up || (w_diff_ew < DB_N && r_az_pos != 12'd0);
    assign w_el_up   = w_diff_ns > DB_P && r_el_pos < EL_TOP;
    assign w_el_req  = w_el_up || (w_diff_ns < DB_N && r_el_pos != 12'd0);

`ifdef SUN_TRACKER_NIGHT_HOME_EN
    localparam int NW = $clog2(NIGHT_EVALS + 1);
    logic          r_night;
    logic [NW-1:0] r_ncnt, w_ncnt_nx;
    logic [17:0]   w_sum;
    logic          w_home;
    assign w_sum      = 18'(r_n) + 18'(r_e) + 18'(r_s) + 18'(r_w);
    assign w_ncnt_nx  = w_sum >= 18'(NIGHT_LUX) ? '0 :
                        r_ncnt == NW'(NIGHT_EVALS) ? r_ncnt : r_ncnt + 1'b1;
    assign w_home     = w_ncnt_nx == NW'(NIGHT_EVALS);
    // Once parked-night is set, every LO phase returns to HOME until both axes reach 0.
    assign w_eval_nx  = w_home ? HOME : w_az_req ? AZ_HI : w_el_req ? EL_HI : IDLE;
    assign w_az_lo_nx = r_night ? HOME : r_el_req ? EL_HI : IDLE;
    assign w_el_lo_nx = r_night ? HOME : IDLE;
    assign bus.night  = r_night;
`else
    assign w_eval_nx  = w_az_req ? AZ_HI : w_el_req ? EL_HI : IDLE;
    assign w_az_lo_nx = r_el_req ? EL_HI : IDLE;
    assign w_el_lo_nx = IDLE;
    assign bus.night  = 1'b0;
`endif

    assign bus.az_step = r_az_step;
    assign bus.az_dir  = r_az_dir;
    assign bus.el_step = r_el_step;
    assign bus.el_dir  = r_el_dir;
    assign bus.az_pos  = r_az_pos;
    assign bus.el_pos  = r_el_pos;
    assign bus.busy    = r_state != IDLE;

    always_ff @(posedge clk)
        if (rst || !bus.enable) r_tick <= '0;
        else r_tick <= w_tick ? '0 : r_tick + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ph      <= '0;
            r_n       <= '0;
            r_e       <= '0;
            r_s       <= '0;
            r_w       <= '0;
            r_az_step <= 1'b0;
            r_az_dir  <= 1'b0;
            r_el_step <= 1'b0;
            r_el_dir  <= 1'b0;
            r_el_req  <= 1'b0;
            r_az_pos  <= '0;
            r_el_pos  <= '0;
`ifdef SUN_TRACKER_NIGHT_HOME_EN
            r_night   <= 1'b0;
            r_ncnt    <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: if (w_tick) begin
                    r_n     <= bus.n_lux;
                    r_e     <= bus.e_lux;
                    r_s     <= bus.s_lux;
                    r_w     <= bus.w_lux;
                    r_state <= EVAL;
                end
                EVAL: begin
                    r_az_dir  <= w_az_up;
                    r_el_dir  <= w_el_up;
                    r_el_req  <= w_el_req;
                    r_ph      <= '0;
                    r_az_step <= w_eval_nx == AZ_HI;
                    r_el_step <= w_eval_nx == EL_HI;
                    r_state   <= w_eval_nx;
`ifdef SUN_TRACKER_NIGHT_HOME_EN
                    r_ncnt    <= w_ncnt_nx;
                    r_night   <= w_home;
`endif
                end
                AZ_HI: begin
                    r_ph <= w_hi_end ? '0 : r_ph + 1'b1;
                    if (w_hi_end) begin
                        r_az_step <= 1'b0;
                        r_az_pos  <= r_az_dir ? r_az_pos + 1'b1 : r_az_pos - 1'b1;
                        r_state   <= AZ_LO;
                    end
                end
                AZ_LO: begin
                    r_ph <= w_lo_end ? '0 : r_ph + 1'b1;
                    if (w_lo_end) begin
                        r_el_step <= w_az_lo_nx == EL_HI;
                        r_state   <= w_az_lo_nx;
                    end
                end
                EL_HI: begin
                    r_ph <= w_hi_end ? '0 : r_ph + 1'b1;
                    if (w_hi_end) begin
                        r_el_step <= 1'b0;
                        r_el_pos  <= r_el_dir ? r_el_pos + 1'b1 : r_el_pos - 1'b1;
                        r_state   <= EL_LO;
                    end
                end
                EL_LO: begin
                    r_ph <= w_lo_end ? '0 : r_ph + 1'b1;
                    if (w_lo_end) r_state <= w_el_lo_nx;
                end
`ifdef SUN_TRACKER_NIGHT_HOME_EN
                HOME: begin
                    r_az_dir  <= 1'b0;
                    r_el_dir  <= 1'b0;
                    r_ph      <= '0;
                    r_az_step <= r_az_pos != 12'd0;
                    r_el_step <= r_az_pos == 12'd0 && r_el_pos != 12'd0;
                    r_state   <= r_az_pos != 12'd0 ? AZ_HI : r_el_pos != 12'd0 ? EL_HI : IDLE;
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
